// File: rtl/lgn_pkg.sv
// Shared types and sizing helpers for the logic-gate-network frame sequencer.
package lgn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    EVAL,
    SEND_REQ,
    SEND_WAIT
  } state_t;

  localparam int DEF_INPUT_BITS     = 400;
  localparam int DEF_OUTPUT_BITS    = 200;
  localparam int DEF_BITS_PER_VALUE = 5;

  function automatic int input_bytes(input int bits);
    return bits / 8;
  endfunction

  function automatic int tx_values(input int out_bits, input int bits_per_value);
    return out_bits / bits_per_value;
  endfunction

  // Counter width that can index 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lgn_frame_assembler.sv
// Collects RX bytes into a shadow frame, tracks the inter-byte gap and flags
// the byte that completes a frame (commit) or an abandoned partial frame.
module lgn_frame_assembler
  import lgn_pkg::*;
#(
  parameter int INPUT_BITS     = 400,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  start,
  input  logic                  recv,
  output logic [INPUT_BITS-1:0] frame,
  output logic                  commit,
  output logic                  timeout
);

  localparam int INPUT_BYTES = input_bytes(INPUT_BITS);
  localparam int IDX_W       = cnt_width(INPUT_BYTES);
  localparam int GAP_W       = cnt_width(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] TOP_IDX   = IDX_W'(INPUT_BYTES - 1);
  localparam logic [IDX_W-1:0] START_IDX = IDX_W'((INPUT_BYTES > 1) ? INPUT_BYTES - 2 : 0);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CYCLES - 1);

  logic [INPUT_BITS-1:0] shadow, shadow_next;
  logic [IDX_W-1:0]      byte_idx, slot;
  logic [GAP_W-1:0]      gap_cnt;
  logic                  take;

  // The frame output already contains the byte accepted this cycle, so a
  // commit can hand over the complete frame without an extra cycle.
  always_comb begin
    take        = rx_valid && (start || recv);
    slot        = start ? TOP_IDX : byte_idx;
    shadow_next = shadow;
    if (take) begin
      shadow_next[slot*8 +: 8] = rx_data;
    end
    commit  = take && (start ? (INPUT_BYTES == 1) : (byte_idx == '0));
    timeout = recv && !rx_valid && (gap_cnt == GAP_LAST);
  end

  assign frame = shadow_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow   <= '0;
      byte_idx <= '0;
      gap_cnt  <= '0;
    end else begin
      shadow <= shadow_next;
      if (start && rx_valid) begin
        byte_idx <= START_IDX;
        gap_cnt  <= '0;
      end else if (recv) begin
        if (rx_valid) begin
          gap_cnt <= '0;
          if (byte_idx != '0) begin
            byte_idx <= byte_idx - 1'b1;
          end
        end else if (!timeout) begin
          gap_cnt <= gap_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lgn_frame_sequencer.sv
// Frame controller: UART bytes in, atomic commit to the network, wait for its
// latency, then stream the output one value per byte through the TX handshake.
module lgn_frame_sequencer
  import lgn_pkg::*;
#(
  parameter int INPUT_BITS     = DEF_INPUT_BITS,
  parameter int OUTPUT_BITS    = DEF_OUTPUT_BITS,
  parameter int BITS_PER_VALUE = DEF_BITS_PER_VALUE,
  parameter int NET_LATENCY    = 0,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [INPUT_BITS-1:0]  net_x,
  input  logic [OUTPUT_BITS-1:0] net_y,
  output logic [7:0]             tx_data,
  output logic                   tx_send,
  input  logic                   tx_active,
  input  logic                   tx_done,
  output logic                   busy,
  output logic [15:0]            frame_count,
  output logic                   timeout_err,
  output logic                   rx_overrun
);

  localparam int TX_VALUES = tx_values(OUTPUT_BITS, BITS_PER_VALUE);
  localparam int VAL_W     = cnt_width(TX_VALUES);
  localparam int LAT_W     = cnt_width(NET_LATENCY + 1);
  localparam logic [VAL_W-1:0] VAL_LAST = VAL_W'(TX_VALUES - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(NET_LATENCY);

  state_t                 state, state_next;
  logic [INPUT_BITS-1:0]  frame;
  logic [OUTPUT_BITS-1:0] snapshot;
  logic [VAL_W-1:0]       val_idx;
  logic [LAT_W-1:0]       lat_cnt;
  logic                   commit, timeout;

  lgn_frame_assembler #(
    .INPUT_BITS    (INPUT_BITS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_assembler (
    .clk     (clk),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .start   (state == IDLE),
    .recv    (state == RECV),
    .frame   (frame),
    .commit  (commit),
    .timeout (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_send    = (state == SEND_REQ);
    busy       = (state != IDLE);
    case (state)
      IDLE:      if (commit) state_next = EVAL;
                 else if (rx_valid) state_next = RECV;
      RECV:      if (commit) state_next = EVAL;
                 else if (timeout) state_next = IDLE;
      EVAL:      if (lat_cnt == LAT_LAST) state_next = SEND_REQ;
      SEND_REQ:  if (tx_active) state_next = SEND_WAIT;
      SEND_WAIT: if (tx_done) state_next = (val_idx == VAL_LAST) ? IDLE : SEND_REQ;
      default:   state_next = IDLE;
    endcase
  end

  // tx_data follows val_idx, which only moves when entering SEND_REQ.
  assign tx_data = 8'(snapshot[val_idx*BITS_PER_VALUE +: BITS_PER_VALUE]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      net_x       <= '0;
      snapshot    <= '0;
      val_idx     <= '0;
      lat_cnt     <= '0;
      frame_count <= '0;
      timeout_err <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      timeout_err <= timeout;
      rx_overrun  <= rx_valid && (state == EVAL || state == SEND_REQ || state == SEND_WAIT);
      if (commit) begin
        net_x   <= frame;
        lat_cnt <= '0;
      end
      if (state == EVAL) begin
        if (lat_cnt == LAT_LAST) begin
          snapshot <= net_y;
          val_idx  <= '0;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
      end
      if (state == SEND_WAIT && tx_done) begin
        if (val_idx == VAL_LAST) frame_count <= frame_count + 1'b1;
        else                     val_idx     <= val_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lgn_frame_sequencer.sv
// Scoreboard bench for lgn_frame_sequencer with a 3-cycle-latency network stub
// and a UART TX model that answers each tx_send request.
module tb_lgn_frame_sequencer;

  localparam int IB  = 400;
  localparam int OB  = 200;
  localparam int BPV = 5;
  localparam int LAT = 3;
  localparam int TMO = 16;
  localparam int NB  = IB / 8;
  localparam int NV  = OB / BPV;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [IB-1:0] net_x;
  logic [OB-1:0] net_y;
  logic [7:0]    tx_data;
  logic          tx_send;
  logic          tx_active = 1'b0;
  logic          tx_done = 1'b0;
  logic          busy;
  logic [15:0]   frame_count;
  logic          timeout_err;
  logic          rx_overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lgn_frame_sequencer #(
    .INPUT_BITS    (IB),
    .OUTPUT_BITS   (OB),
    .BITS_PER_VALUE(BPV),
    .NET_LATENCY   (LAT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .net_x      (net_x),
    .net_y      (net_y),
    .tx_data    (tx_data),
    .tx_send    (tx_send),
    .tx_active  (tx_active),
    .tx_done    (tx_done),
    .busy       (busy),
    .frame_count(frame_count),
    .timeout_err(timeout_err),
    .rx_overrun (rx_overrun)
  );

  // Network stub: identity of the low output bits or a fixed k mod 32 pattern,
  // delayed by LAT cycles after net_x changes.
  logic          ymode = 1'b0;
  logic [OB-1:0] pattern;
  logic [OB-1:0] y_raw;
  logic [OB-1:0] y_p1 = '0, y_p2 = '0, y_p3 = '0;
  assign y_raw = ymode ? pattern : net_x[OB-1:0];
  always @(posedge clk) begin
    y_p1 <= y_raw;
    y_p2 <= y_p1;
    y_p3 <= y_p2;
  end
  assign net_y = y_p3;

  logic [7:0]    exp_q[$];
  logic [7:0]    fb[NB];
  logic [IB-1:0] exp_frame;
  bit            tx_en = 1'b1;
  int            rise_count = 0;
  logic          prev_send = 1'b0;

  always @(negedge clk) begin
    if (tx_send === 1'b1 && prev_send !== 1'b1) rise_count++;
    prev_send = tx_send;
  end

  // TX model: active 2 cycles after a request, done 10 cycles after that.
  initial forever begin
    @(negedge clk);
    if (tx_en && tx_send === 1'b1) begin
      logic [7:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL tx_unexpected: got %02h, nothing queued", tx_data);
      end else begin
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          bad++;
          $display("[TB] FAIL tx_byte: got %02h want %02h", tx_data, e);
        end
      end
      repeat (2) @(negedge clk);
      tx_active = 1'b1;
      repeat (10) @(negedge clk);
      tx_active = 1'b0;
      tx_done   = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic build_expected();
    for (int i = 0; i < NB; i++) exp_frame[IB-1-8*i -: 8] = fb[i];
    for (int k = 0; k < NV; k++) begin
      if (ymode) exp_q.push_back(8'(k % 32));
      else       exp_q.push_back(8'(exp_frame[k*BPV +: BPV]));
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_data  = fb[i];
      rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit expired);
    expired = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && !tx_active && !tx_done) begin
        expired = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total += 7;
    if (net_x !== '0)        begin bad++; $display("[TB] FAIL reset_net_x: got %h want 0", net_x); end
    if (tx_send !== 1'b0)    begin bad++; $display("[TB] FAIL reset_tx_send: got %b want 0", tx_send); end
    if (tx_data !== 8'h00)   begin bad++; $display("[TB] FAIL reset_tx_data: got %h want 00", tx_data); end
    if (busy !== 1'b0)       begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    if (frame_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_frame_count: got %0d want 0", frame_count); end
    if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_timeout_err: got %b want 0", timeout_err); end
    if (rx_overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_rx_overrun: got %b want 0", rx_overrun); end
    rst = 1'b0;
  endtask

  task automatic test_identity_frame();
    bit expired;
    ymode = 1'b0;
    for (int i = 0; i < NB; i++) fb[i] = 8'(i + 1);
    build_expected();
    rise_count = 0;
    applyStimulus(NB);
    wait_idle(3000, expired);
    total += 7;
    if (expired) begin bad++; $display("[TB] FAIL ident_done: got busy=%b want idle", busy); end
    if (net_x[399:392] !== 8'h01) begin bad++; $display("[TB] FAIL ident_first_byte: got %h want 01", net_x[399:392]); end
    if (net_x[7:0] !== 8'h32) begin bad++; $display("[TB] FAIL ident_last_byte: got %h want 32", net_x[7:0]); end
    if (net_x !== exp_frame) begin bad++; $display("[TB] FAIL ident_net_x: got %h want %h", net_x, exp_frame); end
    if (frame_count !== 16'd1) begin bad++; $display("[TB] FAIL ident_count: got %0d want 1", frame_count); end
    if (rise_count != NV) begin bad++; $display("[TB] FAIL ident_send_rises: got %0d want %0d", rise_count, NV); end
    if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL ident_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_mod32();
    bit expired;
    ymode = 1'b1;
    for (int i = 0; i < NB; i++) fb[i] = 8'($urandom_range(0, 255));
    build_expected();
    applyStimulus(NB);
    wait_idle(3000, expired);
    total += 4;
    if (expired) begin bad++; $display("[TB] FAIL mod32_done: got busy=%b want idle", busy); end
    if (net_x !== exp_frame) begin bad++; $display("[TB] FAIL mod32_net_x: got %h want %h", net_x, exp_frame); end
    if (frame_count !== 16'd2) begin bad++; $display("[TB] FAIL mod32_count: got %0d want 2", frame_count); end
    if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL mod32_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_latency();
    bit expired;
    ymode = 1'b0;
    for (int i = 0; i < NB; i++) fb[i] = 8'(255 - 3 * i);
    build_expected();
    applyStimulus(NB);
    wait_idle(3000, expired);
    total += 3;
    if (expired) begin bad++; $display("[TB] FAIL latency_done: got busy=%b want idle", busy); end
    if (frame_count !== 16'd3) begin bad++; $display("[TB] FAIL latency_count: got %0d want 3", frame_count); end
    if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL latency_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_timeout();
    logic [IB-1:0] prev_net;
    logic [15:0]   prev_fc;
    int            cycles;
    bit            seen, expired;
    prev_net = net_x;
    prev_fc  = frame_count;
    for (int i = 0; i < NB; i++) fb[i] = 8'($urandom_range(0, 255));
    applyStimulus(10);
    cycles = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      if (timeout_err === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total += 5;
    if (!seen) begin bad++; $display("[TB] FAIL timeout_seen: got no pulse want pulse"); end
    if (cycles != TMO) begin bad++; $display("[TB] FAIL timeout_delay: got %0d want %0d", cycles, TMO); end
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL timeout_idle: got busy=%b want 0", busy); end
    if (net_x !== prev_net) begin bad++; $display("[TB] FAIL timeout_net_x: got %h want %h", net_x, prev_net); end
    if (frame_count !== prev_fc) begin bad++; $display("[TB] FAIL timeout_count: got %0d want %0d", frame_count, prev_fc); end
    @(posedge clk);
    #1;
    total++;
    if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL timeout_width: got %b want 0", timeout_err); end
    ymode = 1'b0;
    for (int i = 0; i < NB; i++) fb[i] = 8'($urandom_range(0, 255));
    build_expected();
    applyStimulus(NB);
    wait_idle(3000, expired);
    total += 4;
    if (expired) begin bad++; $display("[TB] FAIL recover_done: got busy=%b want idle", busy); end
    if (net_x !== exp_frame) begin bad++; $display("[TB] FAIL recover_net_x: got %h want %h", net_x, exp_frame); end
    if (frame_count !== 16'(prev_fc + 1)) begin bad++; $display("[TB] FAIL recover_count: got %0d want %0d", frame_count, prev_fc + 1); end
    if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL recover_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_overrun();
    logic [15:0] prev_fc;
    bit          found, expired;
    prev_fc = frame_count;
    ymode = 1'b1;
    for (int i = 0; i < NB; i++) fb[i] = 8'($urandom_range(0, 255));
    build_expected();
    applyStimulus(NB);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_active === 1'b1 && tx_send === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin bad++; $display("[TB] FAIL overrun_reach_wait: got no SEND_WAIT want SEND_WAIT"); end
    rx_data  = 8'hEE;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (rx_overrun !== 1'b1) begin bad++; $display("[TB] FAIL overrun_pulse: got %b want 1", rx_overrun); end
    @(negedge clk);
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (rx_overrun !== 1'b0) begin bad++; $display("[TB] FAIL overrun_width: got %b want 0", rx_overrun); end
    wait_idle(3000, expired);
    total += 4;
    if (expired) begin bad++; $display("[TB] FAIL overrun_done: got busy=%b want idle", busy); end
    if (net_x !== exp_frame) begin bad++; $display("[TB] FAIL overrun_net_x: got %h want %h", net_x, exp_frame); end
    if (frame_count !== 16'(prev_fc + 1)) begin bad++; $display("[TB] FAIL overrun_count: got %0d want %0d", frame_count, prev_fc + 1); end
    if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL overrun_missing: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_midframe();
    bit found, expired;
    tx_en = 1'b0;
    ymode = 1'b1;
    for (int i = 0; i < NB; i++) fb[i] = 8'($urandom_range(1, 255));
    applyStimulus(NB);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_send === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    rst = 1'b1;
    #1;
    total += 6;
    if (!found) begin bad++; $display("[TB] FAIL rstsend_reach: got no tx_send want tx_send"); end
    if (tx_send !== 1'b0) begin bad++; $display("[TB] FAIL rstsend_tx_send: got %b want 0", tx_send); end
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstsend_busy: got %b want 0", busy); end
    if (net_x !== '0) begin bad++; $display("[TB] FAIL rstsend_net_x: got %h want 0", net_x); end
    if (tx_data !== 8'h00) begin bad++; $display("[TB] FAIL rstsend_tx_data: got %h want 00", tx_data); end
    if (frame_count !== 16'd0) begin bad++; $display("[TB] FAIL rstsend_count: got %0d want 0", frame_count); end
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(5);
    total++;
    if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rstrecv_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstrecv_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    tx_en = 1'b1;
    for (int i = 0; i < NB; i++) fb[i] = 8'($urandom_range(0, 255));
    build_expected();
    applyStimulus(NB);
    wait_idle(3000, expired);
    total += 4;
    if (expired) begin bad++; $display("[TB] FAIL rstclean_done: got busy=%b want idle", busy); end
    if (net_x !== exp_frame) begin bad++; $display("[TB] FAIL rstclean_net_x: got %h want %h", net_x, exp_frame); end
    if (frame_count !== 16'd1) begin bad++; $display("[TB] FAIL rstclean_count: got %0d want 1", frame_count); end
    if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL rstclean_missing: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    for (int k = 0; k < NV; k++) pattern[k*BPV +: BPV] = 5'(k % 32);
    test_reset();
    test_identity_frame();
    test_mod32();
    test_latency();
    test_timeout();
    test_overrun();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
